// File: rtl/my_cpu_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access sequencer.
// Holds the funct3 access codes and the FSM state encoding.
package my_cpu_mem_ctrl_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } memctrl_state_t;

endpackage

// File: rtl/my_cpu_mem_ctrl_if.sv
// Word-aligned handshaked data-memory bus.
// master = access sequencer, slave = memory.
interface my_cpu_mem_ctrl_if;

  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr,
    output mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr,
    input  mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/my_cpu_mem_ctrl_align.sv
// Combinational lane logic: legality, store lanes, load extract.
// Byte offset is the low two address bits.
module my_cpu_mem_ctrl_align
  import my_cpu_mem_ctrl_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_legal,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  // Legality and store lane generation per access type
  always_comb begin
    o_legal = 1'b0;
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    case (i_type)
      RW_B: begin
        o_legal = 1'b1;
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      RW_H: begin
        o_legal = ~i_off[0];
        o_wstrb = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      RW_W: begin
        o_legal = (i_off == 2'b00);
        o_wstrb = 4'b1111;
      end
      RW_BU: o_legal = ~i_we;
      RW_HU: o_legal = ~i_we & ~i_off[0];
      default: o_legal = 1'b0;
    endcase
    if (!i_we)
      o_wstrb = 4'b0000;
  end

  // Load data extraction and extension
  always_comb begin
    o_ldata = w_sh;
    case (i_type)
      RW_B:  o_ldata = {{24{w_sh[7]}}, w_sh[7:0]};
      RW_H:  o_ldata = {{16{w_sh[15]}}, w_sh[15:0]};
      RW_BU: o_ldata = {24'h0, w_sh[7:0]};
      RW_HU: o_ldata = {16'h0, w_sh[15:0]};
      default: o_ldata = w_sh;
    endcase
  end

endmodule

// File: rtl/my_cpu_mem_ctrl.sv
// Multi-cycle load/store sequencer between datapath and data memory.
// FSM IDLE -> BUSY -> DONE/ERR -> IDLE with optional bus timeout.
module my_cpu_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        MemRW,
  input  logic [2:0]  RWType,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] cpu_rdata,
  my_cpu_mem_ctrl_if.master bus
);

  import my_cpu_mem_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  memctrl_state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic        r_we;
  logic [2:0]  r_type;
  logic [1:0]  r_off;
  logic        r_valid;
  logic        r_mwe;
  logic [31:0] r_maddr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;

  logic        w_idle;
  logic        w_we;
  logic [2:0]  w_type;
  logic [1:0]  w_off;
  logic        w_legal;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_idle = (r_state == ST_IDLE);
  assign w_we   = w_idle ? MemRW : r_we;
  assign w_type = w_idle ? RWType : r_type;
  assign w_off  = w_idle ? cpu_addr[1:0] : r_off;

  my_cpu_mem_ctrl_align u_align (
    .i_we    (w_we),
    .i_type  (w_type),
    .i_off   (w_off),
    .i_wdata (cpu_wdata),
    .i_rdata (bus.mem_rdata),
    .o_legal (w_legal),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  // Pipeline freeze: follows request in IDLE, held through BUSY
  always_comb begin
    stall = 1'b0;
    if (r_state == ST_IDLE)
      stall = cpu_req;
    else if (r_state == ST_BUSY)
      stall = 1'b1;
  end

  assign done          = r_done;
  assign err           = r_err;
  assign cpu_rdata     = (r_state == ST_ERR) ? 32'h0 : r_rdata;
  assign bus.mem_valid = r_valid;
  assign bus.mem_we    = r_mwe;
  assign bus.mem_addr  = r_maddr;
  assign bus.mem_wstrb = r_wstrb;
  assign bus.mem_wdata = r_wdata;

  // Access FSM, wait counter, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_type  <= 3'b000;
      r_off   <= 2'b00;
      r_valid <= 1'b0;
      r_mwe   <= 1'b0;
      r_maddr <= 32'h0;
      r_wstrb <= 4'b0000;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_we   <= MemRW;
            r_type <= RWType;
            r_off  <= cpu_addr[1:0];
            r_cnt  <= '0;
            if (w_legal) begin
              r_state <= ST_BUSY;
              r_valid <= 1'b1;
              r_mwe   <= MemRW;
              r_maddr <= {cpu_addr[31:2], 2'b00};
              r_wstrb <= w_wstrb;
              r_wdata <= w_wdata;
            end else begin
              r_state <= ST_ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (bus.mem_ready) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_mwe   <= 1'b0;
            r_wstrb <= 4'b0000;
            r_done  <= 1'b1;
            if (!r_we)
              r_rdata <= w_ldata;
          end else if ((TIMEOUT != 0) && (r_cnt == LP_LAST)) begin
            r_state <= ST_ERR;
            r_valid <= 1'b0;
            r_mwe   <= 1'b0;
            r_wstrb <= 4'b0000;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_cpu_mem_ctrl.sv
// Self-checking bench for my_cpu_mem_ctrl.
// Transaction-level model with directed and random accesses.
module tb_my_cpu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        MemRW;
  logic [2:0]  RWType;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] cpu_rdata;

  int n_run  = 0;
  int n_fail = 0;

  my_cpu_mem_ctrl_if bus ();

  my_cpu_mem_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .MemRW     (MemRW),
    .RWType    (RWType),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .cpu_rdata (cpu_rdata),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_legal(input bit we, input int ty,
                                 input int off);
    bit ok;
    ok = 1'b0;
    if (ty == 0) ok = 1'b1;
    if (ty == 1 || ty == 5) ok = (off % 2 == 0);
    if (ty == 2) ok = (off == 0);
    if (ty == 4) ok = 1'b1;
    if (we && ty >= 4) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] m_load(input int ty, input int off,
                                         input logic [31:0] word);
    int unsigned v;
    v = word >> (8 * off);
    if (ty == 0) return 32'($signed(v[7:0]));
    if (ty == 1) return 32'($signed(v[15:0]));
    if (ty == 4) return v % 256;
    if (ty == 5) return v % 65536;
    return word;
  endfunction

  function automatic logic [3:0] m_strb(input int ty, input int off);
    if (ty == 0) return 4'(1 << off);
    if (ty == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int ty,
                                          input logic [31:0] d);
    if (ty == 0) return (d & 32'hFF) * 32'h01010101;
    if (ty == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  logic [31:0] last_ld = 32'h0;

  task automatic access(input bit we, input int ty,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits);
    int off;
    bit legal;
    bit tmo;
    int cyc;
    off   = int'(a[1:0]);
    legal = m_legal(we, ty, off);
    tmo   = (waits >= TO);
    cyc   = tmo ? TO : waits + 1;
    cpu_req   = 1'b1;
    MemRW     = we;
    RWType    = 3'(ty);
    cpu_addr  = a;
    cpu_wdata = wd;
    #1;
    chk("stall_req", 32'(stall), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (!legal) begin
      chk("ill_done", 32'(done), 32'd1);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_valid", 32'(bus.mem_valid), 32'd0);
      chk("ill_stall", 32'(stall), 32'd0);
      chk("ill_rdata", cpu_rdata, 32'h0);
    end else begin
      chk("addr", bus.mem_addr, {a[31:2], 2'b00});
      chk("we", 32'(bus.mem_we), 32'(we));
      chk("wstrb", 32'(bus.mem_wstrb), we ? 32'(m_strb(ty, off)) : 0);
      if (we) chk("wdata", bus.mem_wdata, m_wdata(ty, wd));
      for (int i = 0; i < cyc; i++) begin
        chk("busy_valid", 32'(bus.mem_valid), 32'd1);
        chk("busy_stall", 32'(stall), 32'd1);
        chk("busy_done", 32'(done), 32'd0);
        if (i == waits) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd;
        end else begin
          bus.mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end
      chk("fin_done", 32'(done), 32'd1);
      chk("fin_err", 32'(err), 32'(tmo));
      chk("fin_stall", 32'(stall), 32'd0);
      chk("fin_valid", 32'(bus.mem_valid), 32'd0);
      if (tmo) begin
        chk("tmo_rdata", cpu_rdata, 32'h0);
      end else begin
        if (!we) last_ld = m_load(ty, off, rd);
        chk("ld_rdata", cpu_rdata, last_ld);
      end
    end
    cpu_req = $urandom_range(0, 1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("back_idle", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0;
    MemRW = 1'b0;
    RWType = 3'b010;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_strb", 32'(bus.mem_wstrb), 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(0, 2, 32'h100, 0, 32'hDEADBEEF, 0);
    access(0, 0, 32'h103, 0, 32'h80FFFFFF, 0);
    access(0, 4, 32'h103, 0, 32'h80FFFFFF, 1);
    access(0, 5, 32'h102, 0, 32'hBEEF1234, 2);
    access(1, 0, 32'h201, 32'h12345678, 0, 0);
    access(1, 1, 32'h202, 32'h12345678, 0, 1);
    access(0, 2, 32'h102, 0, 0, 0);
    access(1, 1, 32'h101, 0, 0, 0);
    access(0, 3, 32'h100, 0, 0, 0);
    access(0, 2, 32'h300, 0, 32'h1, TO - 1);

    access(0, 2, 32'h400, 0, 32'h5, 99);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("late_done", 32'(done), 32'd0);
    chk("late_valid", 32'(bus.mem_valid), 32'd0);
    chk("late_rdata", cpu_rdata, last_ld);

    cpu_req = 1'b1;
    MemRW = 1'b0;
    RWType = 3'b010;
    cpu_addr = 32'h500;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstb_valid", 32'(bus.mem_valid), 32'd0);
    chk("rstb_stall", 32'(stall), 32'd0);
    chk("rstb_done", 32'(done), 32'd0);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("rstb_ign", 32'(done), 32'd0);
    last_ld = 32'h0;
    access(0, 2, 32'h600, 0, 32'hCAFEF00D, 1);

    for (int k = 0; k < 60; k++) begin
      int tys[8];
      tys = '{0, 1, 2, 4, 5, 3, 6, 7};
      access($urandom_range(0, 1), tys[$urandom_range(0, 7)],
             $urandom, $urandom, $urandom,
             $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
